// File: rtl/sr_latch_sequencer.sv
// sr_latch_sequencer
//   Serialises set/clear requests from N_REQ requesters onto a NOR SR latch.
//   Requests are served round-robin. Each operation drives one timed pulse on
//   S or R, then holds both low for a settle window. It then reads back Q/Qn
//   through a 2-flop synchronizer and reports pass/fail with a completion
//   strobe.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     req_set, req_clr  per-requester level requests (clear wins if both set)
//     gnt               one-hot completion strobe to the served requester
//     done, err         completion strobe; err qualifies it (readback bad)
//     busy              high whenever the FSM is not idle
//     latch_s, latch_r  mutually exclusive drives to the latch cell
//     latch_q, latch_qn asynchronous readback from the latch cell
//     state_q           last verified latch state
//
//   Optional build macro SR_SEQ_SKIP_REDUNDANT_EN: a request that would drive
//   the latch to its already-verified state completes immediately, without
//   pulsing the latch.
module sr_latch_sequencer #(
   parameter int N_REQ         = 4,
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_set,
   input  logic [N_REQ-1:0] req_clr,
   output logic [N_REQ-1:0] gnt,
   output logic             done,
   output logic             err,
   output logic             busy,
   output logic             latch_s,
   output logic             latch_r,
   input  logic             latch_q,
   input  logic             latch_qn,
   output logic             state_q
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("N_REQ must be in 2..8");
   end
   if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse
      $error("PULSE_CYCLES must be in 1..15");
   end
   // The settle window must cover the 2-flop readback synchronizer.
   if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 2..15");
   end

   typedef enum logic [2:0] {S_IDLE, S_PULSE, S_SETTLE, S_CHECK, S_DONE} fsm_t;

   fsm_t             cur_st, nxt_st;
   logic [IDX_W-1:0] ptr, idx, cand, sel_idx, idx_nxt;
   logic             op_clr, sel_clr, sel_found, op_nxt;
   logic [3:0]       cnt;
   logic [1:0]       q_sync, qn_sync;
   logic             chk_fail, skip_c;
   logic [N_REQ-1:0] gnt_nxt;
   logic             done_nxt, err_nxt, busy_nxt, s_nxt, r_nxt;

`ifdef SR_SEQ_SKIP_REDUNDANT_EN
   logic             valid;
`endif

   // Round-robin pick: first active index at or after ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_clr   = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((32'(ptr) + k) % N_REQ);
         if (!sel_found && (req_set[cand] || req_clr[cand])) begin
            sel_found = 1'b1;
            sel_idx   = cand;
            sel_clr   = req_clr[cand];
         end
      end
   end

`ifdef SR_SEQ_SKIP_REDUNDANT_EN
   assign skip_c = valid && ((!sel_clr) == state_q);
`else
   assign skip_c = 1'b0;
`endif

   // SET expects q=1,qn=0; CLR expects q=0,qn=1. Q==Qn always fails.
   assign chk_fail = !((q_sync[1] == !op_clr) && (qn_sync[1] == op_clr));

   // State register
   always_ff @(posedge clk) begin
      if (rst) cur_st <= S_IDLE;
      else     cur_st <= nxt_st;
   end

   // Next-state logic
   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         S_IDLE:   if (sel_found) nxt_st = skip_c ? S_DONE : S_PULSE;
         S_PULSE:  if (cnt == 4'd1) nxt_st = S_SETTLE;
         S_SETTLE: if (cnt == 4'd1) nxt_st = S_CHECK;
         S_CHECK:  nxt_st = S_DONE;
         S_DONE:   nxt_st = S_IDLE;
         default:  nxt_st = S_IDLE;
      endcase
   end

   // Output logic: decoded from the upcoming state so every output is a flop.
   always_comb begin
      op_nxt   = (cur_st == S_IDLE) ? sel_clr : op_clr;
      idx_nxt  = (cur_st == S_IDLE) ? sel_idx : idx;
      gnt_nxt  = '0;
      if (nxt_st == S_DONE) gnt_nxt = ONE_HOT0 << idx_nxt;
      done_nxt = (nxt_st == S_DONE);
      err_nxt  = (cur_st == S_CHECK) && chk_fail;
      busy_nxt = (nxt_st != S_IDLE);
      s_nxt    = (nxt_st == S_PULSE) && !op_nxt;
      r_nxt    = (nxt_st == S_PULSE) && op_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt     <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         latch_s <= 1'b0;
         latch_r <= 1'b0;
      end else begin
         gnt     <= gnt_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         busy    <= busy_nxt;
         latch_s <= s_nxt;
         latch_r <= r_nxt;
      end
   end

   // Datapath: pointer, captured request, counter, synchronizer, result.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= '0;
         idx     <= '0;
         op_clr  <= 1'b0;
         cnt     <= '0;
         q_sync  <= '0;
         qn_sync <= '0;
         state_q <= 1'b0;
`ifdef SR_SEQ_SKIP_REDUNDANT_EN
         valid   <= 1'b0;
`endif
      end else begin
         q_sync  <= {q_sync[0], latch_q};
         qn_sync <= {qn_sync[0], latch_qn};
         case (cur_st)
            S_IDLE: begin
               if (sel_found) begin
                  idx    <= sel_idx;
                  op_clr <= sel_clr;
                  cnt    <= 4'(PULSE_CYCLES);
               end
            end
            S_PULSE: begin
               if (cnt == 4'd1) cnt <= 4'(SETTLE_CYCLES);
               else             cnt <= cnt - 4'd1;
            end
            S_SETTLE: cnt <= cnt - 4'd1;
            S_CHECK: begin
               if (!chk_fail) state_q <= !op_clr;
`ifdef SR_SEQ_SKIP_REDUNDANT_EN
               valid <= !chk_fail;
`endif
            end
            S_DONE: ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
`timescale 1ns/1ps
module tb_sr_latch_sequencer;

   localparam int N  = 4;
   localparam int PC = 2;
   localparam int SC = 3;
   localparam int LAT_FULL = PC + SC + 2;

   logic         clk;
   logic         rst;
   logic [N-1:0] req_set, req_clr, gnt;
   logic         done, err, busy, latch_s, latch_r, latch_q, latch_qn, state_q;

   sr_latch_sequencer #(
      .N_REQ         (N),
      .PULSE_CYCLES  (PC),
      .SETTLE_CYCLES (SC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_set  (req_set),
      .req_clr  (req_clr),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .latch_s  (latch_s),
      .latch_r  (latch_r),
      .latch_q  (latch_q),
      .latch_qn (latch_qn),
      .state_q  (state_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   // Latch cell model with injectable readback faults (1: q=qn=0, 2: q=qn=1).
   logic lq = 1'b0;
   int   fault = 0;
   always @(posedge clk) begin
      if (latch_s && !latch_r)      lq <= 1'b1;
      else if (latch_r && !latch_s) lq <= 1'b0;
   end
   assign latch_q  = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : lq;
   assign latch_qn = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : !lq;

   typedef struct {
      logic [N-1:0] gnt;
      logic         err;
      logic         sq;
      int unsigned  cyc;
      int           s_pulses;
      int           r_pulses;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: pops the scoreboard on every done strobe.
   exp_t mon_e;
   int   s_cnt = 0, r_cnt = 0;
   logic prev_s = 1'b0, prev_r = 1'b0;
   always @(negedge clk) begin
      if (latch_s || latch_r)
         check("s_r_exclusive",
               32'((latch_s && latch_r) || (latch_s && prev_r) || (latch_r && prev_s)), 0);
      if (done || (gnt != '0))
         check("gnt_done_coincide", {30'd0, done, 1'($countones(gnt) == 1)}, 32'd3);
      if (latch_s) s_cnt++;
      if (latch_r) r_cnt++;
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(gnt), 0);
         end else begin
            mon_e = sb.pop_front();
            check("gnt",        32'(gnt),     32'(mon_e.gnt));
            check("err",        32'(err),     32'(mon_e.err));
            check("state_q",    32'(state_q), 32'(mon_e.sq));
            check("done_cycle", cyc,          mon_e.cyc);
            check("s_pulses",   s_cnt,        mon_e.s_pulses);
            check("r_pulses",   r_cnt,        mon_e.r_pulses);
         end
         s_cnt = 0;
         r_cnt = 0;
      end else if (!busy) begin
         s_cnt = 0;
         r_cnt = 0;
      end
      prev_s = latch_s;
      prev_r = latch_r;
   end

   // Reference model state: round-robin pointer, verified state, op timing.
   int m_ptr = 0, m_wait = 0, m_idx = 0, rst_budget = 3;
   bit m_sq = 0, m_valid = 0, m_inflight = 0, m_full = 0, rst_pend = 0;

   task automatic arbitrate();
      bit   found = 0, op_clr = 0, skip = 0, e_err = 0;
      int   j = 0, lat;
      exp_t e;
      for (int k = 0; k < N; k++) begin
         if (!found && (req_set[(m_ptr + k) % N] || req_clr[(m_ptr + k) % N])) begin
            found = 1;
            j     = (m_ptr + k) % N;
         end
      end
      if (!found) return;
      op_clr = req_clr[j];
`ifdef SR_SEQ_SKIP_REDUNDANT_EN
      skip = m_valid && ((!op_clr) == m_sq);
`endif
      if (skip) begin
         lat        = 1;
         e.s_pulses = 0;
         e.r_pulses = 0;
      end else begin
         lat        = LAT_FULL;
         fault      = ($urandom % 10 < 7) ? 0 : int'($urandom_range(1, 2));
         e_err      = (fault != 0);
         e.s_pulses = op_clr ? 0 : PC;
         e.r_pulses = op_clr ? PC : 0;
         if (!e_err) m_sq = !op_clr;
         m_valid = !e_err;
      end
      e.gnt = N'(1) << j;
      e.err = e_err;
      e.sq  = m_sq;
      e.cyc = cyc + lat;
      sb.push_back(e);
      m_ptr      = (j + 1) % N;
      m_idx      = j;
      m_full     = !skip;
      m_inflight = 1;
      m_wait     = lat + 1;
   endtask

   // Called once per negedge: drives inputs for the next active edge.
   task automatic step(input bit allow_new);
      bit [1:0] t;
      if (rst_pend) begin
         check("reset_outputs", {22'd0, gnt, done, err, busy, latch_s, latch_r, state_q}, 0);
         rst      = 1'b0;
         rst_pend = 0;
      end
      if (m_wait > 0) m_wait--;
      if (m_inflight && m_wait == 1) begin
         // Requester handshake; sometimes it keeps holding as a new request.
         if ($urandom % 4 != 0) begin
            req_set[m_idx] = 1'b0;
            req_clr[m_idx] = 1'b0;
         end
         m_inflight = 0;
      end
      if (m_inflight && m_wait > 1 && $urandom % 8 == 0) begin
         t = 2'($urandom_range(0, 3));
         req_set[m_idx] = t[0];
         req_clr[m_idx] = t[1];
      end
      if (allow_new) begin
         for (int i = 0; i < N; i++) begin
            if (!req_set[i] && !req_clr[i] && !(m_inflight && i == m_idx) && $urandom % 6 == 0) begin
               t = 2'($urandom_range(1, 3));
               req_set[i] = t[0];
               req_clr[i] = t[1];
            end
         end
         // Abort in the second PULSE cycle.
         if (rst_budget > 0 && m_inflight && m_full && m_wait == LAT_FULL - 1 &&
             $urandom % 4 == 0) begin
            rst        = 1'b1;
            rst_pend   = 1;
            rst_budget--;
            sb.delete();
            m_ptr      = 0;
            m_sq       = 0;
            m_valid    = 0;
            m_inflight = 0;
            m_wait     = 1;
            return;
         end
      end
      if (m_wait == 0) arbitrate();
   endtask

   initial begin
      rst     = 1'b1;
      req_set = '0;
      req_clr = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {22'd0, gnt, done, err, busy, latch_s, latch_r, state_q}, 0);
      rst = 1'b0;
      repeat (3000) begin
         step(1);
         @(negedge clk);
      end
      for (int i = 0; i < 400; i++) begin
         if (sb.size() == 0 && m_wait == 0 && req_set == '0 && req_clr == '0 && !rst_pend) break;
         step(0);
         @(negedge clk);
      end
      check("drain_outstanding", sb.size(), 0);
      check("reset_aborts_done", 32'(3 - rst_budget > 0), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
